// File: rtl/sched_pkg.sv
// Shared definitions for the instruction-buffer issue scheduler and the
// dependency table that indexes the same buffer slots.
package sched_pkg;

  localparam int BS_DEFAULT = 16;

  function automatic int iw(input int bs);
    return $clog2(bs);
  endfunction

  // Slot index type, also used as the dependency table's buffer_index
  typedef logic [iw(BS_DEFAULT)-1:0] slot_idx_t;

endpackage

// File: rtl/dep_issue_scheduler_if.sv
// Allocation / issue / completion bundle between decode, the scheduler and the
// execution units. The slave side is the scheduler.
interface dep_issue_scheduler_if #(
  parameter int BS = 16
);
  localparam int IW = $clog2(BS);

  logic          alloc_valid;
  logic          alloc_ready;
  logic [IW-1:0] alloc_index;
  logic [BS-1:0] alloc_idt;
  logic          issue_valid;
  logic          issue_ready;
  logic [IW-1:0] issue_index;
  logic          complete_valid;
  logic [IW-1:0] complete_index;
  logic [IW:0]   count;
  logic          empty;
  logic          full;
  logic          cpl_err;

  modport slave (
    input  alloc_valid, alloc_idt, issue_ready, complete_valid, complete_index,
    output alloc_ready, alloc_index, issue_valid, issue_index, count, empty,
           full, cpl_err
  );

  modport master (
    output alloc_valid, alloc_idt, issue_ready, complete_valid, complete_index,
    input  alloc_ready, alloc_index, issue_valid, issue_index, count, empty,
           full, cpl_err
  );

endinterface

// File: rtl/oldest_pick.sv
// Circular priority pick: the first set request at or after i_base (with wrap)
// wins. Rotate so the base lands at bit 0, priority-encode, then un-rotate.
module oldest_pick #(
  parameter  int BS = 16,
  localparam int IW = $clog2(BS)
) (
  input  logic [BS-1:0] i_req,
  input  logic [IW-1:0] i_base,
  output logic          o_gnt_valid,
  output logic [IW-1:0] o_gnt_idx
);

  logic [BS-1:0] w_rot;
  logic [IW-1:0] w_off;
  logic          w_hit;

  // Index arithmetic is IW bits wide, so the rotation wraps for free.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < BS; k++) begin
      w_rot[k] = i_req[IW'(k) + i_base];
    end
  end

  always_comb begin
    w_off = '0;
    w_hit = 1'b0;
    for (int k = BS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IW'(k);
        w_hit = 1'b1;
      end
    end
  end

  assign o_gnt_valid = w_hit;
  assign o_gnt_idx   = w_hit ? (w_off + i_base) : '0;

endmodule

// File: rtl/dep_issue_scheduler.sv
// Out-of-order issue controller: circular slot allocation, per-slot dependency
// rows, oldest-ready issue, and completion wakeup.
module dep_issue_scheduler
  import sched_pkg::*;
#(
  parameter  int BS = BS_DEFAULT,
  localparam int IW = iw(BS)
) (
  input  logic                    clk,
  input  logic                    rst,
  dep_issue_scheduler_if.slave    bus
);

  logic [BS-1:0] r_valid;
  logic [BS-1:0] r_issued;
  logic [BS-1:0] r_dep [BS];
  logic [IW-1:0] r_tail;
  logic [IW:0]   r_count;
  logic          r_cpl_err;

  logic [BS-1:0] w_rdy;
  logic          w_gnt_valid;
  logic [IW-1:0] w_gnt_idx;
  logic          w_alloc_ready;
  logic          w_alloc_fire;
  logic          w_issue_fire;
  logic          w_cpl_ok;
  logic          w_cpl_fire;
  logic [BS-1:0] w_cpl_mask;
  logic [BS-1:0] w_valid_eff;
  logic [BS-1:0] w_tail_mask;

  always_comb begin
    w_rdy = '0;
    for (int k = 0; k < BS; k++) begin
      w_rdy[k] = r_valid[k] & ~r_issued[k] & (r_dep[k] == '0);
    end
  end

  oldest_pick #(.BS(BS)) u_pick (
    .i_req       (w_rdy),
    .i_base      (r_tail),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  assign w_alloc_ready = ~r_valid[r_tail];
  assign w_alloc_fire  = bus.alloc_valid & w_alloc_ready;
  assign w_issue_fire  = w_gnt_valid & bus.issue_ready;
  assign w_cpl_ok      = r_valid[bus.complete_index] & r_issued[bus.complete_index];
  assign w_cpl_fire    = bus.complete_valid & w_cpl_ok;
  assign w_cpl_mask    = w_cpl_fire ? (BS'(1) << bus.complete_index) : '0;
  assign w_valid_eff   = r_valid & ~w_cpl_mask;
  assign w_tail_mask   = BS'(1) << r_tail;

  // Completion, issue and allocation always touch distinct slots: completion
  // needs valid+issued, issue needs valid+!issued, allocation needs !valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= '0;
      r_issued  <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_cpl_err <= 1'b0;
      for (int k = 0; k < BS; k++) begin
        r_dep[k] <= '0;
      end
    end else begin
      for (int k = 0; k < BS; k++) begin
        r_dep[k] <= r_dep[k] & ~w_cpl_mask;
      end
      if (w_cpl_fire) begin
        r_valid[bus.complete_index]  <= 1'b0;
        r_issued[bus.complete_index] <= 1'b0;
      end
      if (w_issue_fire) begin
        r_issued[w_gnt_idx] <= 1'b1;
      end
      if (w_alloc_fire) begin
        r_valid[r_tail]  <= 1'b1;
        r_issued[r_tail] <= 1'b0;
        r_dep[r_tail]    <= bus.alloc_idt & w_valid_eff & ~w_tail_mask;
        r_tail           <= r_tail + 1'b1;
      end
      if (bus.complete_valid && !w_cpl_ok) begin
        r_cpl_err <= 1'b1;
      end
      r_count <= r_count + (IW+1)'(w_alloc_fire) - (IW+1)'(w_cpl_fire);
    end
  end

  assign bus.alloc_ready = w_alloc_ready;
  assign bus.alloc_index = r_tail;
  assign bus.issue_valid = w_gnt_valid;
  assign bus.issue_index = w_gnt_idx;
  assign bus.count       = r_count;
  assign bus.empty       = (r_count == '0);
  assign bus.full        = (r_count == (IW+1)'(BS));
  assign bus.cpl_err     = r_cpl_err;

endmodule

// File: tb/tb_dep_issue_scheduler.sv
// Self-checking bench for dep_issue_scheduler: directed table, corner-case
// sequences and a randomized run against an age-ordered slot model.
module tb_dep_issue_scheduler;

  localparam int BS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dep_issue_scheduler_if #(.BS(BS)) bus ();

  dep_issue_scheduler #(.BS(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: live slots kept in allocation (age) order
  bit          m_valid  [BS];
  bit          m_issued [BS];
  logic [15:0] m_dep    [BS];
  int          m_tail;
  int          q[$];
  bit          m_err;
  bit          m_wrapped;

  typedef struct {
    bit          av;
    logic [15:0] idt;
    bit          ir;
    bit          cv;
    int          ci;
    bit          e_iv;
    int          e_ii;
    int          e_cnt;
    int          e_ai;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int k = 0; k < BS; k++) begin
      m_valid[k] = 0; m_issued[k] = 0; m_dep[k] = '0;
    end
    m_tail = 0; q.delete(); m_err = 0; m_wrapped = 0;
  endfunction

  function automatic void m_pick(output bit v, output int idx);
    v = 0; idx = 0;
    foreach (q[i]) begin
      if (!v && !m_issued[q[i]] && m_dep[q[i]] == 16'h0) begin
        v = 1; idx = q[i];
      end
    end
  endfunction

  function automatic void m_step(input bit av, input logic [15:0] idt,
                                 input bit ir, input bit cv, input int ci);
    bit pv; int pidx; bit ar; bit ok; logic [15:0] veff;
    ar = !m_valid[m_tail];
    m_pick(pv, pidx);
    ok = cv && m_valid[ci] && m_issued[ci];
    if (cv && !ok) m_err = 1;
    veff = '0;
    for (int k = 0; k < BS; k++) veff[k] = m_valid[k];
    if (ok) begin
      veff[ci] = 1'b0;
      m_valid[ci] = 0; m_issued[ci] = 0;
      for (int k = 0; k < BS; k++) m_dep[k][ci] = 1'b0;
      foreach (q[i]) if (q[i] == ci) begin q.delete(i); break; end
    end
    if (pv && ir) m_issued[pidx] = 1;
    if (av && ar) begin
      m_valid[m_tail] = 1; m_issued[m_tail] = 0;
      m_dep[m_tail] = idt & veff & ~(16'h1 << m_tail);
      q.push_back(m_tail);
      if (m_tail == BS - 1) m_wrapped = 1;
      m_tail = (m_tail + 1) % BS;
    end
  endfunction

  task automatic check_outputs();
    bit pv; int pidx;
    m_pick(pv, pidx);
    chk("alloc_ready", int'(bus.alloc_ready), int'(!m_valid[m_tail]));
    chk("alloc_index", int'(bus.alloc_index), m_tail);
    chk("issue_valid", int'(bus.issue_valid), int'(pv));
    chk("issue_index", int'(bus.issue_index), pidx);
    chk("count", int'(bus.count), q.size());
    chk("empty", int'(bus.empty), int'(q.size() == 0));
    chk("full", int'(bus.full), int'(q.size() == BS));
    chk("cpl_err", int'(bus.cpl_err), int'(m_err));
  endtask

  // Called just after a negedge; drives inputs, checks, steps through one edge
  task automatic cyc(input bit av, input logic [15:0] idt, input bit ir,
                     input bit cv, input int ci);
    bus.alloc_valid    = av;
    bus.alloc_idt      = idt;
    bus.issue_ready    = ir;
    bus.complete_valid = cv;
    bus.complete_index = ci[3:0];
    #1;
    check_outputs();
    m_step(av, idt, ir, cv, ci);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.alloc_valid = 0; bus.alloc_idt = '0; bus.issue_ready = 0;
    bus.complete_valid = 0; bus.complete_index = '0;
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_alloc_ready", int'(bus.alloc_ready), 1);
    chk("rst_alloc_index", int'(bus.alloc_index), 0);
    chk("rst_issue_valid", int'(bus.issue_valid), 0);
    chk("rst_issue_index", int'(bus.issue_index), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_cpl_err", int'(bus.cpl_err), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 16'h0, 1'b1, 1'b0, 0, 1'b0, 0, 0, 0};
    tbl[1] = '{1'b1, 16'h0, 1'b1, 1'b0, 0, 1'b1, 0, 1, 1};
    tbl[2] = '{1'b1, 16'h0, 1'b1, 1'b0, 0, 1'b1, 1, 2, 2};
    tbl[3] = '{1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b1, 2, 3, 3};
    tbl[4] = '{1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0, 0, 3, 3};

    do_reset();

    // In-order issue of three independent slots
    for (int i = 0; i < 5; i++) begin
      chk("tbl_issue_valid", int'(bus.issue_valid), int'(tbl[i].e_iv));
      chk("tbl_issue_index", int'(bus.issue_index), tbl[i].e_ii);
      chk("tbl_count", int'(bus.count), tbl[i].e_cnt);
      chk("tbl_alloc_index", int'(bus.alloc_index), tbl[i].e_ai);
      cyc(tbl[i].av, tbl[i].idt, tbl[i].ir, tbl[i].cv, tbl[i].ci);
    end

    // Dependency chain: slot1 waits for slot0's completion, wakes 1 cycle later
    do_reset();
    cyc(1, 16'h0000, 1, 0, 0);
    cyc(1, 16'h0001, 1, 0, 0);
    chk("chain_wait", int'(bus.issue_valid), 0);
    cyc(0, 16'h0000, 1, 0, 0);
    chk("chain_wait2", int'(bus.issue_valid), 0);
    cyc(0, 16'h0000, 0, 1, 0);
    chk("chain_wake_valid", int'(bus.issue_valid), 1);
    chk("chain_wake_index", int'(bus.issue_index), 1);

    // Fill the buffer, then free a non-tail slot, then the tail slot
    do_reset();
    for (int i = 0; i < BS; i++) cyc(1, 16'h0000, 1, 0, 0);
    chk("fill_full", int'(bus.full), 1);
    chk("fill_alloc_ready", int'(bus.alloc_ready), 0);
    cyc(0, 16'h0000, 1, 1, 5);
    chk("free5_alloc_ready", int'(bus.alloc_ready), 0);
    chk("free5_count", int'(bus.count), 15);
    cyc(0, 16'h0000, 0, 1, 0);
    chk("free0_alloc_ready", int'(bus.alloc_ready), 1);
    chk("free0_alloc_index", int'(bus.alloc_index), 0);
    cyc(1, 16'h0000, 0, 0, 0);
    chk("realloc_index", int'(bus.alloc_index), 1);
    chk("realloc_ready", int'(bus.alloc_ready), 0);
    chk("realloc_count", int'(bus.count), 15);

    // Same-cycle completion drops the matching dependency bit of the new slot
    do_reset();
    for (int i = 0; i < 4; i++) cyc(i < 3, 16'h0000, 1, 0, 0);
    cyc(1, 16'h0004, 1, 1, 2);
    chk("same_cyc_valid", int'(bus.issue_valid), 1);
    chk("same_cyc_index", int'(bus.issue_index), 3);
    chk("same_cyc_count", int'(bus.count), 3);

    // Illegal completion, then asynchronous reset mid-run
    do_reset();
    cyc(1, 16'h0000, 0, 0, 0);
    cyc(0, 16'h0000, 0, 1, 0);
    chk("bad_cpl_err", int'(bus.cpl_err), 1);
    chk("bad_cpl_count", int'(bus.count), 1);
    chk("bad_cpl_offer", int'(bus.issue_valid), 1);
    cyc(1, 16'h0000, 1, 0, 0);
    do_reset();

    // Randomized traffic with legal completions
    for (int it = 0; it < 400; it++) begin
      int iss[$];
      bit cv;
      int ci;
      foreach (q[i]) if (m_issued[q[i]]) iss.push_back(q[i]);
      cv = (iss.size() > 0) && ($urandom_range(0, 99) < 50);
      ci = cv ? iss[$urandom_range(0, iss.size() - 1)] : int'($urandom_range(0, BS - 1));
      cyc($urandom_range(0, 99) < 70, 16'($urandom & $urandom), $urandom_range(0, 99) < 70,
          cv, ci);
    end
    chk("tail_wrapped", int'(m_wrapped), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
